// File: rtl/block_stream_pkg.sv
// Shared definitions for the begin/end block stream emitter: command and
// state encodings, ASCII constants, token lengths and a case helper.
package block_stream_pkg;

    typedef enum logic [1:0] {
        CMD_BEGIN  = 2'b00,
        CMD_END    = 2'b01,
        CMD_FILLER = 2'b10,
        CMD_SPACE  = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_TAIL = 2'd2
    } state_e;

    // Character index inside a token; the longest token has 5 letters.
    localparam int IDX_W = 3;
    localparam logic [IDX_W-1:0] IDX_ZERO = '0;
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_B     = 8'h62;
    localparam logic [7:0] CHAR_D     = 8'h64;
    localparam logic [7:0] CHAR_E     = 8'h65;
    localparam logic [7:0] CHAR_G     = 8'h67;
    localparam logic [7:0] CHAR_I     = 8'h69;
    localparam logic [7:0] CHAR_N     = 8'h6E;
    localparam logic [7:0] CHAR_X     = 8'h78;
    localparam logic [7:0] CHAR_LC_A  = 8'h61;
    localparam logic [7:0] CHAR_LC_Z  = 8'h7A;
    localparam logic [7:0] CASE_DELTA = 8'h20;

    localparam logic [IDX_W-1:0] LEN_BEGIN  = 3'd5;
    localparam logic [IDX_W-1:0] LEN_END    = 3'd3;
    localparam logic [IDX_W-1:0] LEN_FILLER = 3'd2;

    // Letter count of a token (the trailing space is not included).
    function automatic logic [IDX_W-1:0] token_len(input cmd_e t);
        case (t)
            CMD_BEGIN:  return LEN_BEGIN;
            CMD_END:    return LEN_END;
            CMD_FILLER: return LEN_FILLER;
            default:    return IDX_ZERO;
        endcase
    endfunction

    // Lowercase ASCII letter to uppercase; everything else passes through.
    function automatic logic [7:0] to_upper(input logic [7:0] c);
        if (c >= CHAR_LC_A && c <= CHAR_LC_Z)
            return c - CASE_DELTA;
        return c;
    endfunction

endpackage

// File: rtl/block_token_rom.sv
// Combinational token text lookup: (token, index, case select) gives the
// ASCII letter at that position and whether it is the token's last letter.
module block_token_rom
    import block_stream_pkg::*;
(
    input  cmd_e             token,
    input  logic [IDX_W-1:0] index,
    input  logic             upper,
    output logic [7:0]       ch,
    output logic             last
);

    logic [7:0] lower;

    // Letter table; out-of-range positions read as a space.
    always_comb begin
        lower = CHAR_SPACE;
        case (token)
            CMD_BEGIN: begin
                case (index)
                    3'd0:    lower = CHAR_B;
                    3'd1:    lower = CHAR_E;
                    3'd2:    lower = CHAR_G;
                    3'd3:    lower = CHAR_I;
                    3'd4:    lower = CHAR_N;
                    default: lower = CHAR_SPACE;
                endcase
            end
            CMD_END: begin
                case (index)
                    3'd0:    lower = CHAR_E;
                    3'd1:    lower = CHAR_N;
                    3'd2:    lower = CHAR_D;
                    default: lower = CHAR_SPACE;
                endcase
            end
            CMD_FILLER: begin
                case (index)
                    3'd0:    lower = CHAR_B;
                    3'd1:    lower = CHAR_X;
                    default: lower = CHAR_SPACE;
                endcase
            end
            default: lower = CHAR_SPACE;
        endcase
    end

    assign ch   = upper ? to_upper(lower) : lower;
    // SPACE has no letters, so it never reports a last letter.
    assign last = (token != CMD_SPACE) && (index == token_len(token) - IDX_ONE);

endmodule

// File: rtl/block_stream_emitter.sv
// Serialises BEGIN/END/FILLER/SPACE commands into an ASCII character stream
// (letters plus one trailing space) and tracks nesting depth for the block
// checker. Define UPPERCASE_EN to emit letters in uppercase.
module block_stream_emitter
    import block_stream_pkg::*;
#(
    parameter int DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd,
    output logic               cmd_ready,
    output logic [7:0]         out_char,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DEPTH_W-1:0] depth,
    output logic               balanced,
    output logic               err
);

`ifdef UPPERCASE_EN
    localparam logic UPPER = 1'b1;
`else
    localparam logic UPPER = 1'b0;
`endif

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};

    state_e           state;
    cmd_e             tok;
    logic [IDX_W-1:0] idx;
    logic             on_last;   // the character now on out_char is the token's last letter

    cmd_e             cmd_in;
    cmd_e             tok_sel;
    logic [IDX_W-1:0] idx_sel;
    logic [7:0]       rom_ch;
    logic             rom_last;

    assign cmd_in = cmd_e'(cmd);

    // The ROM always looks up the character that will be registered next:
    // letter 0 of the incoming command in IDLE, the following letter otherwise.
    always_comb begin
        tok_sel = tok;
        idx_sel = idx + IDX_ONE;
        if (state == ST_IDLE) begin
            tok_sel = cmd_in;
            idx_sel = IDX_ZERO;
        end
    end

    block_token_rom u_rom (
        .token (tok_sel),
        .index (idx_sel),
        .upper (UPPER),
        .ch    (rom_ch),
        .last  (rom_last)
    );

    // Token FSM with registered handshake outputs and depth/error tracking.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            tok       <= CMD_SPACE;
            idx       <= IDX_ZERO;
            on_last   <= 1'b0;
            cmd_ready <= 1'b1;
            out_valid <= 1'b0;
            out_char  <= CHAR_SPACE;
            depth     <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        tok       <= cmd_in;
                        idx       <= IDX_ZERO;
                        cmd_ready <= 1'b0;
                        out_valid <= 1'b1;
                        if (cmd_in == CMD_SPACE) begin
                            state    <= ST_TAIL;
                            out_char <= CHAR_SPACE;
                            on_last  <= 1'b0;
                        end else begin
                            state    <= ST_EMIT;
                            out_char <= rom_ch;
                            on_last  <= rom_last;
                        end
                        // Depth saturates at both ends; hitting either end is sticky.
                        case (cmd_in)
                            CMD_BEGIN: begin
                                if (depth == DEPTH_MAX) err <= 1'b1;
                                else                    depth <= depth + DEPTH_ONE;
                            end
                            CMD_END: begin
                                if (depth == '0) err <= 1'b1;
                                else             depth <= depth - DEPTH_ONE;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (on_last) begin
                            state    <= ST_TAIL;
                            out_char <= CHAR_SPACE;
                            on_last  <= 1'b0;
                        end else begin
                            idx      <= idx_sel;
                            out_char <= rom_ch;
                            on_last  <= rom_last;
                        end
                    end
                end
                ST_TAIL: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign balanced = (depth == '0) && !err;

endmodule

// File: tb/tb_block_stream_emitter.sv
// Self-checking bench for block_stream_emitter: directed scenarios plus
// randomized command/back-pressure traffic against a string-level model.
module tb_block_stream_emitter;

    localparam int DW   = 3;
    localparam int DMAX = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd = 2'b00;
    logic          cmd_ready;
    logic [7:0]    out_char;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] depth;
    logic          balanced;
    logic          err;

    int         vectors = 0;
    int         miscompares = 0;
    int         m_depth = 0;
    bit         m_err = 1'b0;
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    block_stream_emitter #(.DEPTH_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .out_char  (out_char),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .depth     (depth),
        .balanced  (balanced),
        .err       (err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Text a command should produce, trailing space included.
    function automatic string tok_text(input logic [1:0] c);
        string s;
        case (c)
            2'b00:   s = "begin ";
            2'b01:   s = "end ";
            2'b10:   s = "bx ";
            default: s = " ";
        endcase
`ifdef UPPERCASE_EN
        s = s.toupper();
`endif
        return s;
    endfunction

    task automatic model_cmd(input logic [1:0] c);
        if (c == 2'b00) begin
            if (m_depth == DMAX) m_err = 1'b1;
            else                 m_depth++;
        end else if (c == 2'b01) begin
            if (m_depth == 0) m_err = 1'b1;
            else              m_depth--;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cmd_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        reset = 1'b1;
        m_depth = 0;
        m_err = 1'b0;
        got_q.delete();
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_depth"}, depth, m_depth);
        chk({tag, "_err"}, err, m_err);
        chk({tag, "_bal"}, balanced, (m_depth == 0) && !m_err);
    endtask

    // Present one command in IDLE, then check depth/err the cycle after accept.
    task automatic accept(input logic [1:0] c);
        chk("ready_before_cmd", cmd_ready, 1'b1);
        cmd = c;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        cmd = 2'($urandom);
        model_cmd(c);
        chk_status("accept");
    endtask

    // Drain the token, capturing transfers and checking that stalled data holds.
    task automatic collect(input bit rnd);
        int n = 0;
        bit held = 1'b0;
        logic [7:0] hc = 8'h00;
        while (!cmd_ready && n < 300) begin
            if (held) chk("stall_hold", out_char, hc);
            held = 1'b0;
            if (out_valid && out_ready) got_q.push_back(out_char);
            else if (out_valid) begin
                held = 1'b1;
                hc = out_char;
            end
            step();
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            n++;
        end
        chk("idle_within_bound", n < 300, 1'b1);
    endtask

    task automatic chk_stream(input string e);
        chk("stream_len", got_q.size(), e.len());
        for (int i = 0; i < e.len() && i < got_q.size(); i++)
            chk($sformatf("stream_char%0d", i), got_q[i], e[i]);
    endtask

    task automatic run_cmd(input logic [1:0] c, input bit rnd);
        got_q.delete();
        out_ready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
        accept(c);
        collect(rnd);
        chk_stream(tok_text(c));
    endtask

    initial begin
        string e;

        // Reset state
        do_reset();
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_char", out_char, 8'h20);
        chk("rst_depth", depth, 0);
        chk("rst_balanced", balanced, 1'b1);
        chk("rst_err", err, 1'b0);

        // BEGIN cycle timing with out_ready held high
        e = tok_text(2'b00);
        cmd = 2'b00;
        cmd_valid = 1'b1;
        out_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        cmd = 2'b01;
        model_cmd(2'b00);
        chk("begin_depth", depth, 1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("begin_t%0d_char", i + 1), out_char, e[i]);
            chk($sformatf("begin_t%0d_valid", i + 1), out_valid, 1'b1);
            chk($sformatf("begin_t%0d_ready", i + 1), cmd_ready, 1'b0);
            step();
        end
        chk("begin_t7_cmd_ready", cmd_ready, 1'b1);
        chk("begin_t7_out_valid", out_valid, 1'b0);

        // Continue BEGIN, FILLER, END
        run_cmd(2'b10, 1'b0);
        run_cmd(2'b01, 1'b0);
        chk("seq_balanced", balanced, 1'b1);

        // Underflow: END at depth 0, then a BEGIN/END pair keeps err
        run_cmd(2'b01, 1'b0);
        chk("underflow_err", err, 1'b1);
        chk("underflow_depth", depth, 0);
        run_cmd(2'b00, 1'b0);
        run_cmd(2'b01, 1'b0);
        chk("err_sticky", err, 1'b1);
        run_cmd(2'b11, 1'b0);

        // Stall pattern 1,0,0,1 during BEGIN
        do_reset();
        e = tok_text(2'b00);
        cmd = 2'b00;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        model_cmd(2'b00);
        chk("stall_c0", out_char, e[0]);
        got_q.push_back(out_char);
        step();
        out_ready = 1'b0;
        chk("stall_c1a", out_char, e[1]);
        step();
        chk("stall_c1b", out_char, e[1]);
        step();
        chk("stall_c1c", out_char, e[1]);
        chk("stall_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        collect(1'b0);
        chk_stream(e);

        // Reset mid-token after three letters have transferred
        do_reset();
        cmd = 2'b00;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        step();
        reset = 1'b0;
        step();
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_depth", depth, 0);
        chk("midrst_cmd_ready", cmd_ready, 1'b1);
        chk("midrst_out_char", out_char, 8'h20);
        chk("midrst_err", err, 1'b0);
        reset = 1'b1;
        m_depth = 0;
        m_err = 1'b0;
        run_cmd(2'b00, 1'b0);

        // Overflow: one BEGIN past the maximum depth
        do_reset();
        for (int i = 0; i <= DMAX; i++) run_cmd(2'b00, 1'b1);
        chk("overflow_depth", depth, DMAX);
        chk("overflow_err", err, 1'b1);

        // Random commands under random back-pressure
        do_reset();
        for (int i = 0; i < 40; i++) run_cmd(2'($urandom_range(0, 3)), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/block_stream_emitter.md
Name: block_stream_emitter

Overview:
- Generates the ASCII character stream consumed by the begin/end block checker, one character per cycle under a valid/ready handshake.
- Accepts token commands (BEGIN, END, FILLER, SPACE) and serialises each token as characters plus one trailing space.
- Tracks nesting depth and exposes balance/error status so benches and the stream source can predict the checker's verdict.

Parameters:
- DEPTH_W, 8, width of the nesting-depth counter; maximum depth is 2^DEPTH_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- cmd_valid  input  1  a command is presented.
- cmd  input  2  00 BEGIN, 01 END, 10 FILLER, 11 SPACE.
- cmd_ready  output  1  the emitter can accept a command.
- out_char  output  8  current ASCII character.
- out_valid  output  1  out_char is valid.
- out_ready  input  1  the sink accepts out_char this cycle.
- depth  output  DEPTH_W  current nesting depth.
- balanced  output  1  high when depth==0 and err==0.
- err  output  1  sticky flag for an underflow or overflow event.

Behaviour:
- Reset (clk edge with reset==0): state IDLE; cmd_ready=1, out_valid=0, out_char=8'h20, depth=0, err=0, balanced=1. Any token in flight is abandoned.
- Handshakes:
  - A command is accepted when cmd_valid && cmd_ready.
  - A character transfers when out_valid && out_ready.
  - out_char and out_valid hold stable while out_ready==0.
- FSM states: IDLE, EMIT, TAIL.
  - IDLE: cmd_ready=1, out_valid=0. On accept, latch the token and set char index=0. BEGIN, END and FILLER go to EMIT. SPACE goes directly to TAIL.
  - EMIT: cmd_ready=0, out_valid=1, out_char = token[index]. Token texts are "begin" (5 characters), "end" (3) and "bx" (2). On transfer, index increments; on transfer of the last letter, go to TAIL.
  - TAIL: out_valid=1, out_char=" ". On transfer, go to IDLE.
- Latency: the first character is valid the cycle after accept. With out_ready held at 1, a token of n letters occupies n+1 output cycles. cmd_ready re-asserts the cycle after the space transfers, so BEGIN repeats at most every 7 cycles.
- Depth updates on the accept cycle and is visible the next cycle:
  - BEGIN at depth < max: depth+1.
  - BEGIN at max: depth saturates and err is set.
  - END at depth > 0: depth-1.
  - END at depth 0: depth stays 0 and err is set. The characters are still emitted.
  - FILLER and SPACE leave depth unchanged.
- err is sticky until reset.
- balanced is combinational from depth and err.
- cmd is sampled only on accept. Changes on cmd while cmd_ready==0 are ignored.
- Reset asserted mid-token: the next cycle out_valid=0 and all state is as at reset. No partial character is re-emitted.

Optional Feature:
- UPPERCASE_EN defined: token letters are emitted in uppercase ("BEGIN", "END", "BX"); the space is unchanged.
- UPPERCASE_EN undefined: token letters are emitted in lowercase.
- Timing and depth behaviour are identical in both builds.

Decomposition:
- Shared package block_stream_pkg holds:
  - cmd encodings CMD_BEGIN, CMD_END, CMD_FILLER, CMD_SPACE;
  - FSM state encodings;
  - ASCII constants, including CHAR_SPACE;
  - per-token lengths.
- One sub-module, block_token_rom: combinational (token, index, case select) -> ASCII character and last-letter flag.

Test Plan:
- Reset low for 2 cycles, then high: cmd_ready=1, out_valid=0, depth=0, balanced=1, err=0.
- BEGIN accepted at cycle t with out_ready=1: out_char = 62,65,67,69,6E,20 on cycles t+1..t+6; depth=1 from t+1; cmd_ready=1 at t+7.
- Command sequence BEGIN, FILLER, END: stream is "begin bx end "; depth goes 1,1,0; balanced=1 at the end.
- END at depth 0: "end " is emitted, depth stays 0, err=1, balanced=0; a following BEGIN/END pair leaves err=1.
- out_ready toggled 1,0,0,1 during BEGIN: out_char holds 65 while stalled; the total stream is still "begin ".
- Reset pulsed after 3 letters of BEGIN: out_valid=0 the next cycle and depth=0. With UPPERCASE_EN defined, a repeated BEGIN yields 42,45,47,49,4E,20.
